// File: rtl/fxp_disp_pkg.sv
// Shared types and constants for the fixed-point display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package fxp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV_INT  = 2'd1,
    CONV_FRAC = 2'd2,
    COMMIT    = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Scan order: sign first (digit_an bit5), hundredths last (digit_an bit0)
  localparam logic [2:0] POS_SIGN     = 3'd0;
  localparam logic [2:0] POS_HUNDREDS = 3'd1;
  localparam logic [2:0] POS_TENS     = 3'd2;
  localparam logic [2:0] POS_UNITS    = 3'd3;
  localparam logic [2:0] POS_TENTHS   = 3'd4;
  localparam logic [2:0] POS_HUND     = 3'd5;

  // Double-dabble correction applied to each BCD nibble before a shift
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/fxp_seg_decode.sv
// Combinational BCD digit to active-low 7-segment code; blank or
// non-decimal input gives an unlit position.
module fxp_seg_decode
  import fxp_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_DIGITS[digit];
    end
  end

endmodule

// File: rtl/fxp_display_scanner.sv
// Q9.6 value to six-position multiplexed 7-segment display, converted by
// sequential double-dabble. Optional overflow blink: FXP_DISP_OVF_BLINK_EN.
module fxp_display_scanner
  import fxp_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_BITS  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic        load_ovf,
  output logic        done,
  output logic [6:0]  seg,
  output logic [5:0]  digit_an
);

  localparam int RW = $clog2(REFRESH_DIV);

  // Handshake: a value transfers on a clock edge where load_valid && load_ready;
  // load_ready is high only in IDLE, so offers during a conversion are held off.
  state_e state_q, state_d;
  logic   accept, conv_int_step, conv_frac_step, commit;

  logic [3:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [20:0]      int_sr_q, int_sr_d, int_adj;
  logic [14:0]      frac_sr_q, frac_sr_d, frac_adj;
  logic [14:0]      mag;
  logic [6:0]       frac;
  logic [4:0][3:0]  c_dig_q, c_dig_d;
  logic             c_neg_q, c_neg_d;
  logic             done_q, done_d;
  logic [RW-1:0]    refresh_q, refresh_d;
  logic [2:0]       index_q, index_d;
  logic             wrap;
  logic [6:0]       seg_q, seg_d, dec_seg;
  logic [5:0]       an_q, an_d;
  logic [3:0]       dec_digit;
  logic             dec_blank;
  logic             blank_all;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (load_valid)     state_d = CONV_INT;
      CONV_INT:  if (cnt_q == 4'd8)  state_d = CONV_FRAC;
      CONV_FRAC: if (cnt_q == 4'd6)  state_d = COMMIT;
      COMMIT:                        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready     = (state_q == IDLE);
    accept         = load_valid && (state_q == IDLE);
    conv_int_step  = (state_q == CONV_INT);
    conv_frac_step = (state_q == CONV_FRAC);
    commit         = (state_q == COMMIT);
  end

  // 0x8000 negates to 0x8000, whose 15-bit truncation is zero: shown as "-  0.00"
  always_comb begin
    mag      = load_value[15] ? 15'(~load_value[14:0] + 15'd1) : load_value[14:0];
    frac     = 7'((13'(mag[5:0]) * 13'd100) >> 6);
    int_adj  = {dd_adj(int_sr_q[20:17]), dd_adj(int_sr_q[16:13]),
                dd_adj(int_sr_q[12:9]), int_sr_q[8:0]};
    frac_adj = {dd_adj(frac_sr_q[14:11]), dd_adj(frac_sr_q[10:7]), frac_sr_q[6:0]};

    cnt_d     = cnt_q;
    neg_d     = neg_q;
    int_sr_d  = int_sr_q;
    frac_sr_d = frac_sr_q;
    c_dig_d   = c_dig_q;
    c_neg_d   = c_neg_q;
    done_d    = commit;

    if (accept) begin
      cnt_d     = 4'd0;
      neg_d     = load_value[15];
      int_sr_d  = {12'd0, mag[14:6]};
      frac_sr_d = {8'd0, frac};
    end
    if (conv_int_step) begin
      int_sr_d = int_adj << 1;
      cnt_d    = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
    end
    if (conv_frac_step) begin
      frac_sr_d = frac_adj << 1;
      cnt_d     = cnt_q + 4'd1;
    end
    if (commit) begin
      c_dig_d = {int_sr_q[20:9], frac_sr_q[14:7]};
      c_neg_d = neg_q;
    end
  end

`ifdef FXP_DISP_OVF_BLINK_EN
  logic                  ovf_q, ovf_d, c_ovf_q, c_ovf_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;

  always_comb begin
    ovf_d     = accept ? load_ovf : ovf_q;
    c_ovf_d   = commit ? ovf_q : c_ovf_q;
    blink_d   = blink_q + BLINK_BITS'(1);
    blank_all = c_ovf_q && blink_q[BLINK_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      c_ovf_q <= 1'b0;
      blink_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      c_ovf_q <= c_ovf_d;
      blink_q <= blink_d;
    end
  end
`else
  localparam int unused_blink_bits = BLINK_BITS;
  logic unused_ovf;
  assign unused_ovf = load_ovf;
  assign blank_all  = 1'b0;
`endif

  always_comb begin
    dec_digit = 4'd0;
    dec_blank = 1'b1;
    unique case (index_q)
      POS_HUNDREDS: begin dec_digit = c_dig_q[4]; dec_blank = (c_dig_q[4] == 4'd0); end
      POS_TENS:     begin dec_digit = c_dig_q[3];
                          dec_blank = (c_dig_q[4] == 4'd0) && (c_dig_q[3] == 4'd0); end
      POS_UNITS:    begin dec_digit = c_dig_q[2]; dec_blank = 1'b0; end
      POS_TENTHS:   begin dec_digit = c_dig_q[1]; dec_blank = 1'b0; end
      POS_HUND:     begin dec_digit = c_dig_q[0]; dec_blank = 1'b0; end
      default:      begin dec_digit = 4'd0;       dec_blank = 1'b1; end
    endcase
  end

  fxp_seg_decode u_dec (
    .digit (dec_digit),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  // Scan runs freely; a commit simply shows up in the next registered output
  always_comb begin
    wrap      = (refresh_q == RW'(REFRESH_DIV - 1));
    refresh_d = wrap ? '0 : refresh_q + RW'(1);
    index_d   = index_q;
    if (wrap) index_d = (index_q == POS_HUND) ? POS_SIGN : index_q + 3'd1;

    an_d  = ~(6'b100000 >> index_q);
    seg_d = (index_q == POS_SIGN) ? (c_neg_q ? SEG_MINUS : SEG_BLANK) : dec_seg;
    if (blank_all) begin
      an_d  = 6'h3F;
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      neg_q     <= 1'b0;
      int_sr_q  <= '0;
      frac_sr_q <= '0;
      c_dig_q   <= '0;
      c_neg_q   <= 1'b0;
      done_q    <= 1'b0;
      refresh_q <= '0;
      index_q   <= POS_SIGN;
      seg_q     <= SEG_BLANK;
      an_q      <= 6'h3F;
    end else begin
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      int_sr_q  <= int_sr_d;
      frac_sr_q <= frac_sr_d;
      c_dig_q   <= c_dig_d;
      c_neg_q   <= c_neg_d;
      done_q    <= done_d;
      refresh_q <= refresh_d;
      index_q   <= index_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign done     = done_q;
  assign seg      = seg_q;
  assign digit_an = an_q;

endmodule

// File: tb/tb_fxp_display_scanner.sv
// Directed bench for fxp_display_scanner with a fast scan (REFRESH_DIV=4)
// and a short blink counter (BLINK_BITS=4).
module tb_fxp_display_scanner;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_BITS  = 4;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic        load_ovf;
  logic        done;
  logic [6:0]  seg;
  logic [5:0]  digit_an;

  int checks = 0;
  int errors = 0;

  fxp_display_scanner #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_BITS  (BLINK_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_ovf   (load_ovf),
    .done       (done),
    .seg        (seg),
    .digit_an   (digit_an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records seg per position (index = digit_an bit) over n cycles
  task automatic capture_frame(input int n, output logic [5:0][6:0] frame,
                               output logic [5:0] mask, output int bad);
    frame = '0;
    mask  = '0;
    bad   = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ($countones(~digit_an) != 1) bad++;
      for (int b = 0; b < 6; b++) begin
        if (digit_an == ~(6'b000001 << b)) begin
          frame[b] = seg;
          mask[b]  = 1'b1;
        end
      end
    end
  endtask

  // Offers one value for a single transfer and watches 40 cycles after it
  task automatic do_load(input logic [15:0] v, input logic ovf, output int done_k,
                         output int pulses, output int ready_low);
    @(negedge clk);
    load_valid = 1'b1;
    load_value = v;
    load_ovf   = ovf;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    load_ovf   = 1'b0;
    done_k = 0;
    pulses = 0;
    ready_low = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pulses++;
        if (done_k == 0) done_k = k;
      end
      if (k <= 16 && !load_ready) ready_low++;
    end
  endtask

  task automatic test_reset();
    logic [5:0][6:0] zf;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    int p;
    zf = {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    checks++; if (digit_an !== 6'h3F) begin errors++; $display("FAIL reset_an got=%h exp=3f", digit_an); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      p = (k - 1) / 4;
      exp_an  = ~(6'b100000 >> p);
      exp_seg = zf[5 - p];
      checks++;
      if (digit_an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL reset_scan k=%0d got an=%h seg=%h exp an=%h seg=%h",
                 k, digit_an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_positive();
    logic [15:0] vals [2];
    logic [5:0][6:0] exp_f [2];
    logic [5:0][6:0] f;
    logic [5:0] m;
    int bad, dk, pl, rl;
    vals[0] = 16'h0C90; exp_f[0] = {7'h7F, 7'h7F, 7'h12, 7'h40, 7'h24, 7'h12};
    vals[1] = 16'h7FFF; exp_f[1] = {7'h7F, 7'h12, 7'h79, 7'h79, 7'h10, 7'h00};
    for (int i = 0; i < 2; i++) begin
      do_load(vals[i], 1'b0, dk, pl, rl);
      checks++; if (dk !== 17) begin errors++; $display("FAIL pos_done_cycle v=%h got=%0d exp=17", vals[i], dk); end
      checks++; if (pl !== 1) begin errors++; $display("FAIL pos_done_pulses v=%h got=%0d exp=1", vals[i], pl); end
      checks++; if (rl !== 16) begin errors++; $display("FAIL pos_ready_low v=%h got=%0d exp=16", vals[i], rl); end
      capture_frame(24, f, m, bad);
      checks++; if (f !== exp_f[i] || m !== 6'h3F) begin
        errors++; $display("FAIL pos_frame v=%h got=%h exp=%h", vals[i], f, exp_f[i]); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL pos_onehot v=%h got=%0d exp=0", vals[i], bad); end
    end
  endtask

  task automatic test_negative();
    logic [15:0] vals [2];
    logic [5:0][6:0] exp_f [2];
    logic [5:0][6:0] f;
    logic [5:0] m;
    int bad, dk, pl, rl;
    vals[0] = 16'hFF80; exp_f[0] = {7'h3F, 7'h7F, 7'h7F, 7'h24, 7'h40, 7'h40};
    vals[1] = 16'h8000; exp_f[1] = {7'h3F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};
    for (int i = 0; i < 2; i++) begin
      do_load(vals[i], 1'b0, dk, pl, rl);
      checks++; if (dk !== 17) begin errors++; $display("FAIL neg_done_cycle v=%h got=%0d exp=17", vals[i], dk); end
      capture_frame(24, f, m, bad);
      checks++; if (f !== exp_f[i] || m !== 6'h3F) begin
        errors++; $display("FAIL neg_frame v=%h got=%h exp=%h", vals[i], f, exp_f[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0][6:0] exp_a, exp_b, fa, f;
    logic [5:0] ma, m;
    int dk1, dk2, rl, ra17, bad, part_err;
    exp_a = {7'h7F, 7'h7F, 7'h19, 7'h79, 7'h40, 7'h40};
    exp_b = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
    fa = '0; ma = '0; dk1 = 0; dk2 = 0; rl = 0; ra17 = 0;
    @(negedge clk);
    load_valid = 1'b1;
    load_value = 16'h0A40;
    @(posedge clk);
    @(negedge clk);
    load_value = 16'h0040;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (dk1 == 0) dk1 = k;
        else if (dk2 == 0) dk2 = k;
      end
      if (k <= 16 && !load_ready) rl++;
      if (k == 17) ra17 = int'(load_ready);
      if (k == 18) load_valid = 1'b0;
      if (k >= 18 && k <= 35) begin
        for (int b = 0; b < 6; b++) begin
          if (digit_an == ~(6'b000001 << b)) begin fa[b] = seg; ma[b] = 1'b1; end
        end
      end
    end
    part_err = 0;
    for (int b = 0; b < 6; b++) if (ma[b] && fa[b] !== exp_a[b]) part_err++;
    checks++; if (rl !== 16) begin errors++; $display("FAIL b2b_ready_low got=%0d exp=16", rl); end
    checks++; if (ra17 !== 1) begin errors++; $display("FAIL b2b_ready_idle got=%0d exp=1", ra17); end
    checks++; if (dk1 !== 17) begin errors++; $display("FAIL b2b_first_done got=%0d exp=17", dk1); end
    checks++; if (dk2 !== 35) begin errors++; $display("FAIL b2b_second_done got=%0d exp=35", dk2); end
    checks++; if (part_err !== 0) begin
      errors++; $display("FAIL b2b_first_frame got=%h exp=%h mask=%b", fa, exp_a, ma); end
    capture_frame(24, f, m, bad);
    checks++; if (f !== exp_b || m !== 6'h3F) begin
      errors++; $display("FAIL b2b_second_frame got=%h exp=%h", f, exp_b); end
  endtask

  task automatic test_reset_mid();
    logic [5:0][6:0] zf, f;
    logic [5:0] m;
    int bad, pulses;
    zf = {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};
    @(negedge clk);
    load_valid = 1'b1;
    load_value = 16'h0C90;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", load_ready); end
    checks++; if (seg !== 7'h7F || digit_an !== 6'h3F) begin
      errors++; $display("FAIL mid_rst_outputs got seg=%h an=%h exp seg=7f an=3f", seg, digit_an); end
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_rst_done got=%0d exp=0", pulses); end
    capture_frame(24, f, m, bad);
    checks++; if (f !== zf || m !== 6'h3F) begin
      errors++; $display("FAIL mid_rst_frame got=%h exp=%h", f, zf); end
  endtask

  task automatic test_ovf();
    logic [5:0][6:0] f;
    logic [5:0] m;
    int bad, dk, pl, rl, blanks;
    do_load(16'h0100, 1'b1, dk, pl, rl);
    checks++; if (dk !== 17) begin errors++; $display("FAIL ovf_done_cycle got=%0d exp=17", dk); end
    blanks = 0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (digit_an == 6'h3F && seg == 7'h7F) blanks++;
    end
`ifdef FXP_DISP_OVF_BLINK_EN
    checks++; if (blanks !== 16) begin errors++; $display("FAIL ovf_blink got=%0d exp=16", blanks); end
`else
    checks++; if (blanks !== 0) begin errors++; $display("FAIL ovf_blink got=%0d exp=0", blanks); end
    capture_frame(24, f, m, bad);
    checks++; if (f !== {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h40, 7'h40} || m !== 6'h3F) begin
      errors++; $display("FAIL ovf_frame got=%h exp=7f7f7f194040", f); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_onehot got=%0d exp=0", bad); end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_value = 16'h0000;
    load_ovf   = 1'b0;
    test_reset();
    test_positive();
    test_negative();
    test_back_to_back();
    test_reset_mid();
    test_ovf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
